boxhead_soc_keyin: RTL and testbench

BOXHEAD_SOC_KEYIN -- requirements
Module: boxhead_soc_keyin

---
 rtl/boxhead_keyin_pkg.sv | 30 +++
 rtl/boxhead_keyin_fifo.sv | 69 ++++++
 rtl/boxhead_soc_keyin.sv | 148 ++++++++++++++
 tb/tb_boxhead_soc_keyin.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boxhead_keyin_pkg.sv
// Purpose: shared constants for the keycode-input block (register map, bit indices, defaults).
// Latency: n/a (constants only).
// Backpressure: n/a.
package boxhead_keyin_pkg;

    // Avalon-MM register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQEN  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // DATA register: keycode in [7:0], not-empty flag here
    localparam int DATA_NE_BIT     = 8;

    // STATUS register: count in [4:0]; OVF is also the write-1-to-clear bit
    localparam int STAT_OVF_BIT    = 8;
    localparam int STAT_FULL_BIT   = 9;

    // IRQEN register
    localparam int IRQEN_IE_BIT    = 0;
    localparam int IRQEN_OVFIE_BIT = 1;

    // CTRL register
    localparam int CTRL_FLUSH_BIT  = 0;

    // Defaults
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_DATA_W  = 8;

endpackage

// File: rtl/boxhead_keyin_fifo.sv
// Purpose: keycode FIFO storage and pointers with push/pop/flush and count/full/empty.
// Latency: a push is visible at o_head_dat the cycle after the write edge.
// Backpressure: pushes while full and pops while empty are ignored; flush beats both.
//
// Ports: clk/reset (sync, active-high); i_push + i_push_dat; i_pop; i_flush;
//        o_head_dat (oldest entry, valid when !o_empty); o_count; o_full; o_empty.
module boxhead_keyin_fifo
    import boxhead_keyin_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head_dat,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage is not reset; only the write itself is suppressed during reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers are PTR_W wide so they wrap modulo DEPTH (power of two) naturally.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/boxhead_soc_keyin.sv
// Purpose: Avalon-MM keycode input port: FIFO of keyboard codes with status, flush and optional IRQ.
// Latency: pushed code readable next cycle; readdata is combinational (zero wait states).
// Backpressure: in_ready = not-full; producer never stalls, so codes offered while full are dropped and flag OVF.
//
// Ports: clk, reset (sync, active-high); Avalon slave address/chipselect/read_n/write_n/
//        writedata/readdata; keycode stream in_valid/in_data/in_ready; irq (KEYIN_IRQ_EN only).
// Build option: define KEYIN_IRQ_EN to add the IRQEN register and the registered irq output.
module boxhead_soc_keyin
    import boxhead_keyin_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready
`ifdef KEYIN_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              w_rd;
    logic              w_wr;
    logic              w_pop;
    logic              w_flush;
    logic              w_ovf_clr;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_head8;
    logic [4:0]        w_count5;
    logic              r_ovf;

    assign w_rd      = chipselect & ~read_n;
    assign w_wr      = chipselect & ~write_n;
    // The FIFO ignores the pop when empty, so an empty DATA read has no effect.
    assign w_pop     = w_rd & (address == ADDR_DATA);
    assign w_flush   = w_wr & (address == ADDR_CTRL)   & writedata[CTRL_FLUSH_BIT];
    assign w_ovf_clr = w_wr & (address == ADDR_STATUS) & writedata[STAT_OVF_BIT];
    // A flush swallows the offered code silently, so it cannot raise OVF.
    assign w_ovf_set = in_valid & w_full & ~w_flush;

    assign in_ready  = ~w_full;

    boxhead_keyin_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (in_valid),
        .i_push_dat (in_data),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef KEYIN_IRQ_EN
    logic r_ie;
    logic r_ovfie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie    <= 1'b0;
            r_ovfie <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && (address == ADDR_IRQEN)) begin
                r_ie    <= writedata[IRQEN_IE_BIT];
                r_ovfie <= writedata[IRQEN_OVFIE_BIT];
            end
            r_irq <= (r_ie & ~w_empty) | (r_ovfie & r_ovf);
        end
    end

    assign irq = r_irq;

    logic w_unused_wdata;
    assign w_unused_wdata = ^{writedata[31:9], writedata[7:2]};
`else
    logic w_unused_wdata;
    assign w_unused_wdata = ^{writedata[31:9], writedata[7:1]};
`endif

    // Zero-extend head and count into their fixed register fields.
    always_comb begin
        w_head8               = '0;
        w_head8[DATA_W-1:0]   = w_head;
        w_count5              = '0;
        w_count5[CNT_W-1:0]   = w_count;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!w_empty) begin
                    readdata[7:0]        = w_head8;
                    readdata[DATA_NE_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                readdata[4:0]          = w_count5;
                readdata[STAT_OVF_BIT]  = r_ovf;
                readdata[STAT_FULL_BIT] = w_full;
            end
            ADDR_IRQEN: begin
`ifdef KEYIN_IRQ_EN
                readdata[IRQEN_IE_BIT]    = r_ie;
                readdata[IRQEN_OVFIE_BIT] = r_ovfie;
`endif
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_boxhead_soc_keyin.sv
// Purpose: directed self-checking bench for boxhead_soc_keyin (DEPTH=4, DATA_W=8).
// Latency: inputs driven on negedge, readdata sampled 1ns later, state checked 1ns after posedge.
// Backpressure: exercises full/overflow, flush and same-cycle push/pop cases.
`timescale 1ns/1ps
module tb_boxhead_soc_keyin;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
`ifdef KEYIN_IRQ_EN
    logic        irq;
`endif

    int nvec;
    int nerr;

    boxhead_soc_keyin #(.DEPTH(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready)
`ifdef KEYIN_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_idle();
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_valid   = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        #1 d = readdata;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] wd);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic push(input logic [7:0] kc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = kc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk); address = 2'd0; #1;
        nvec++;
        if (readdata !== 32'h0) begin nerr++; $display("FAIL reset_data got %h want 00000000", readdata); end
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL reset_status got %h want 00000000", d); end
        cpu_read(2'd2, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL reset_irqen got %h want 00000000", d); end
`ifdef KEYIN_IRQ_EN
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b want 0", irq); end
`endif
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] exp_q [4];
        exp_q = '{32'h11A, 32'h104, 32'h116, 32'h000};
        push(8'h1A); push(8'h04); push(8'h16);
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h003) begin nerr++; $display("FAIL basic_status got %h want 00000003", d); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'd0, d);
            nvec++;
            if (d !== exp_q[i]) begin nerr++; $display("FAIL basic_read%0d got %h want %h", i, d, exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL ovf_in_ready got %b want 0", in_ready); end
        push(8'h14);
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h304) begin nerr++; $display("FAIL ovf_status got %h want 00000304", d); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'd0, d);
            nvec++;
            if (d !== 32'h110 + 32'(i)) begin nerr++; $display("FAIL ovf_read%0d got %h want %h", i, d, 32'h110 + 32'(i)); end
        end
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL ovf_lost got %h want 00000000", d); end
        cpu_write(2'd1, 32'h100);
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL ovf_clear got %h want 00000000", d); end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        in_valid = 1'b1; in_data = 8'h55;
        #1 d = readdata;
        @(posedge clk);
        #1 bus_idle();
        nvec++;
        if (d !== 32'h120) begin nerr++; $display("FAIL fpp_read got %h want 00000120", d); end
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h103) begin nerr++; $display("FAIL fpp_status got %h want 00000103", d); end
        cpu_write(2'd1, 32'h100);
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h003) begin nerr++; $display("FAIL fpp_clear got %h want 00000003", d); end
        for (int i = 1; i < 5; i++) begin
            cpu_read(2'd0, d);
            nvec++;
            if (d !== ((i < 4) ? 32'h120 + 32'(i) : 32'h0)) begin
                nerr++; $display("FAIL fpp_read%0d got %h want %h", i, d, (i < 4) ? 32'h120 + 32'(i) : 32'h0);
            end
        end
    endtask

    task automatic test_flush_push();
        logic [31:0] d;
        push(8'h30);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
        in_valid = 1'b1; in_data = 8'h07;
        @(posedge clk);
        #1 bus_idle();
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL flush_status got %h want 00000000", d); end
        push(8'h08);
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h108) begin nerr++; $display("FAIL flush_next got %h want 00000108", d); end
        // full FIFO, flush with a code offered: no overflow recorded
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
        in_valid = 1'b1; in_data = 8'h99;
        @(posedge clk);
        #1 bus_idle();
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL flush_full_status got %h want 00000000", d); end
        cpu_read(2'd3, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL ctrl_read got %h want 00000000", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        push(8'h41); push(8'h42);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        in_valid = 1'b1; in_data = 8'h43;
        #1 d = readdata;
        @(posedge clk);
        #1 bus_idle();
        nvec++;
        if (d !== 32'h141) begin nerr++; $display("FAIL b2b_read got %h want 00000141", d); end
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h002) begin nerr++; $display("FAIL b2b_status got %h want 00000002", d); end
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h142) begin nerr++; $display("FAIL b2b_read2 got %h want 00000142", d); end
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h143) begin nerr++; $display("FAIL b2b_read3 got %h want 00000143", d); end
    endtask

    task automatic test_no_side_effects();
        logic [31:0] d;
        push(8'h50);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
        @(posedge clk); #1 bus_idle();
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b0; address = 2'd0;
        @(posedge clk); #1 bus_idle();
        cpu_write(2'd0, 32'hFFFF_FFFF);
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h001) begin nerr++; $display("FAIL nocs_status got %h want 00000001", d); end
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h150) begin nerr++; $display("FAIL nocs_read got %h want 00000150", d); end
    endtask

    task automatic test_irqen();
        logic [31:0] d;
        cpu_write(2'd2, 32'h3);
        cpu_read(2'd2, d);
`ifdef KEYIN_IRQ_EN
        nvec++;
        if (d !== 32'h3) begin nerr++; $display("FAIL irqen_rw got %h want 00000003", d); end
        cpu_write(2'd2, 32'h0);
`else
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL irqen_absent got %h want 00000000", d); end
`endif
    endtask

`ifdef KEYIN_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        cpu_write(2'd2, 32'h1);
        push(8'h2C);
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL irq_early got %b want 0", irq); end
        @(posedge clk); #1;
        nvec++;
        if (irq !== 1'b1) begin nerr++; $display("FAIL irq_rise got %b want 1", irq); end
        cpu_read(2'd0, d);
        nvec++;
        if (irq !== 1'b1) begin nerr++; $display("FAIL irq_hold got %b want 1", irq); end
        @(posedge clk); #1;
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL irq_fall got %b want 0", irq); end
        // overflow interrupt
        cpu_write(2'd2, 32'h2);
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
        @(posedge clk); #1;
        nvec++;
        if (irq !== 1'b1) begin nerr++; $display("FAIL irq_ovf got %b want 1", irq); end
        cpu_write(2'd1, 32'h100);
        @(posedge clk); #1;
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL irq_ovf_clr got %b want 0", irq); end
        cpu_write(2'd3, 32'h1);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d;
`ifdef KEYIN_IRQ_EN
        cpu_write(2'd2, 32'h1);
`endif
        push(8'h81); push(8'h82);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        reset = 1'b1;
        @(posedge clk);
        #1 bus_idle(); reset = 1'b0;
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
`ifdef KEYIN_IRQ_EN
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL rmid_irq got %b want 0", irq); end
`endif
        cpu_read(2'd1, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL rmid_status got %h want 00000000", d); end
        cpu_read(2'd0, d);
        nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL rmid_data got %h want 00000000", d); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        in_data = 8'h0;
        bus_idle();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_flush_push();
        test_back_to_back();
        test_no_side_effects();
        test_irqen();
`ifdef KEYIN_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
